// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 9-bit words from a synchronous ROM and feeds them
// to the processor over the run/done/DIN handshake. It handles the MVI
// immediate word, halt/illegal-opcode trapping, a done-timeout watchdog and
// a saturating count of retired instructions.
module instr_sequencer #(
    parameter int AW      = 5,
    parameter int TIMEOUT = 7,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [8:0]    mem_rdata,
    output logic [8:0]    DIN,
    output logic          run,
    input  logic          done,
    output logic          busy,
    output logic          halted,
    output logic          error,
    output logic [AW-1:0] pc,
    output logic [CW-1:0] retired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_MVI  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_IMM, S_WAIT, S_HALTED, S_ERROR
    } state_t;

    state_t        state;
    logic [AW-1:0] pc_q;
    logic [CW-1:0] ret_q;
    logic          stop_pending;
    logic [TW-1:0] timer;

    logic [2:0]    op;
    logic          stop_any;
    logic          op_ill;
    logic          issue_ok;
    logic [AW-1:0] pc_inc;

    // Decode of the word currently on mem_rdata (only meaningful in ISSUE).
    assign op       = mem_rdata[8:6];
    assign stop_any = stop | stop_pending;
    assign op_ill   = (op == 3'b101) || (op == 3'b110);
    assign issue_ok = (state == S_ISSUE) && !stop_any && (op != OP_HALT) && !op_ill;
    assign pc_inc   = pc_q + 1'b1;

    assign pc      = pc_q;
    assign retired = ret_q;
    assign busy    = (state == S_FETCH) || (state == S_ISSUE) ||
                     (state == S_IMM)   || (state == S_WAIT);
    assign halted  = (state == S_HALTED);
    assign error   = (state == S_ERROR);

    // Sequencer state, program counter, watchdog timer and retire counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_IDLE;
            pc_q         <= '0;
            ret_q        <= '0;
            stop_pending <= 1'b0;
            timer        <= '0;
        end else begin
            // A stop seen while busy is remembered until the next boundary;
            // every transition into IDLE below clears it again.
            if (busy && stop)
                stop_pending <= 1'b1;
            case (state)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (start) begin
                        pc_q         <= start_addr;
                        stop_pending <= 1'b0;
                        state        <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (stop_any) begin
                        stop_pending <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (stop_any) begin
                        stop_pending <= 1'b0;
                        state        <= S_IDLE;
                    end else if (op == OP_HALT) begin
                        state <= S_HALTED;
                    end else if (op_ill) begin
                        state <= S_ERROR;
                    end else begin
                        pc_q  <= pc_inc;
                        timer <= '0;
                        state <= (op == OP_MVI) ? S_IMM : S_WAIT;
                    end
                end
                S_IMM: begin
                    pc_q  <= pc_inc;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (done) begin
                        if (ret_q != '1)
                            ret_q <= ret_q + 1'b1;
                        if (stop_any) begin
                            stop_pending <= 1'b0;
                            state        <= S_IDLE;
                        end else begin
                            // Next word was prefetched during WAIT: issue with no bubble.
                            state <= S_ISSUE;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state <= S_ERROR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake and ROM strobes; ISSUE/IMM forward the ROM word straight to DIN.
    always_comb begin
        run      = 1'b0;
        DIN      = '0;
        mem_rd   = 1'b0;
        mem_addr = '0;
        case (state)
            S_FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q;
            end
            S_ISSUE: begin
                if (issue_ok) begin
                    run = 1'b1;
                    DIN = mem_rdata;
                    if (op == OP_MVI) begin
                        mem_rd   = 1'b1;
                        mem_addr = pc_inc;
                    end
                end
            end
            S_IMM: begin
                run = 1'b1;
                DIN = mem_rdata;
            end
            S_WAIT: begin
                run      = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = pc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: drives directed and random programs through the
// sequencer with a small processor-core model, and checks every output on
// every cycle against a trace generated by walking the program.
module tb_instr_sequencer;

    localparam int AW      = 5;
    localparam int TIMEOUT = 7;
    localparam int CW      = 16;
    localparam int MAXC    = 160;

    logic          clk = 1'b0;
    logic          resetn, start, stop;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [8:0]    mem_rdata;
    logic [8:0]    DIN;
    logic          run, done, busy, halted, error;
    logic [AW-1:0] pc;
    logic [CW-1:0] retired;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.AW(AW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .start_addr(start_addr), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .DIN(DIN), .run(run), .done(done),
        .busy(busy), .halted(halted), .error(error), .pc(pc), .retired(retired)
    );

    // Program ROM: one-cycle read latency.
    logic [8:0] rom [32];
    always @(posedge clk)
        if (mem_rd) mem_rdata <= rom[mem_addr];

    // Processor-core model: fixed latency per opcode, executes on done.
    function automatic int lat(input logic [2:0] op);
        case (op)
            3'b000:  return 2;
            3'b001:  return 3;
            3'b100:  return 3;
            default: return 4;
        endcase
    endfunction

    logic       hang_add;
    logic       cbusy;
    int         cstep;
    logic [8:0] cins, cimm;
    logic [8:0] R [8];

    assign done = cbusy && !(hang_add && cins[8:6] == 3'b010) && (cstep == lat(cins[8:6]) - 1);

    always @(posedge clk) begin
        if (!resetn) begin
            cbusy <= 1'b0;
            cstep <= 0;
            for (int i = 0; i < 8; i++) R[i] <= '0;
        end else if (!cbusy) begin
            if (run) begin
                cbusy <= 1'b1;
                cstep <= 1;
                cins  <= DIN;
            end
        end else if (!run) begin
            cbusy <= 1'b0;
        end else begin
            if (cins[8:6] == 3'b100 && cstep == 1) cimm <= DIN;
            if (done) begin
                cbusy <= 1'b0;
                case (cins[8:6])
                    3'b001: R[cins[5:3]] <= R[cins[2:0]];
                    3'b010: R[cins[5:3]] <= R[cins[5:3]] + R[cins[2:0]];
                    3'b011: R[cins[5:3]] <= R[cins[5:3]] - R[cins[2:0]];
                    3'b100: R[cins[5:3]] <= cimm;
                    default: ;
                endcase
            end else begin
                cstep <= cstep + 1;
            end
        end
    end

    typedef struct packed {
        logic          run;
        logic [8:0]    din;
        logic          mem_rd;
        logic [AW-1:0] addr;
        logic          busy;
        logic          halted;
        logic          error;
        logic [AW-1:0] pc;
        logic [CW-1:0] ret;
    } obs_t;

    obs_t          exp_a [MAXC+1];
    obs_t          act_a [MAXC+1];
    logic          done_a [MAXC+1];
    logic [CW-1:0] model_ret;
    int            model_n;

    function automatic obs_t sample();
        obs_t o;
        o.run = run; o.din = DIN; o.mem_rd = mem_rd; o.addr = mem_addr;
        o.busy = busy; o.halted = halted; o.error = error; o.pc = pc; o.ret = retired;
        return o;
    endfunction

    task automatic put(input int c, input obs_t o);
        if (c >= 1 && c <= model_n) exp_a[c] = o;
    endtask

    // Walk the program instruction by instruction and lay down the expected
    // per-cycle observation trace (cycle 1 = first cycle after the start edge).
    task automatic build_model(input logic [AW-1:0] sa, input int stop_cyc, input bit hg, input int ncyc);
        int            c, waits, fin;
        logic [AW-1:0] p;
        logic [CW-1:0] r;
        bit            sp;
        logic [8:0]    w;
        logic [2:0]    op;
        obs_t          o;
        model_n = ncyc;
        p = sa; r = model_ret; sp = 0; c = 1; fin = -1;
        o = '0; o.busy = 1; o.mem_rd = 1; o.addr = p; o.pc = p; o.ret = r;
        put(c, o);
        if (c == stop_cyc) fin = 0;
        c++;
        while (fin < 0 && c <= ncyc) begin
            w = rom[p]; op = w[8:6];
            o = '0; o.busy = 1; o.pc = p; o.ret = r;
            if (c == stop_cyc || sp) begin
                put(c, o); fin = 0; c++;
            end else if (op == 3'b111) begin
                put(c, o); fin = 1; c++;
            end else if (op == 3'b101 || op == 3'b110) begin
                put(c, o); fin = 2; c++;
            end else begin
                o.run = 1; o.din = w;
                if (op == 3'b100) begin o.mem_rd = 1; o.addr = p + 1'b1; end
                put(c, o);
                p = p + 1'b1; c++;
                if (op == 3'b100) begin
                    o = '0; o.busy = 1; o.run = 1; o.din = rom[p]; o.pc = p; o.ret = r;
                    put(c, o);
                    if (c == stop_cyc) sp = 1;
                    p = p + 1'b1; c++;
                end
                waits = (hg && op == 3'b010) ? TIMEOUT : lat(op) - 1 - ((op == 3'b100) ? 1 : 0);
                for (int k = 0; k < waits; k++) begin
                    o = '0; o.busy = 1; o.run = 1; o.mem_rd = 1; o.addr = p; o.pc = p; o.ret = r;
                    put(c, o);
                    if (c == stop_cyc) sp = 1;
                    c++;
                end
                if (hg && op == 3'b010) begin
                    fin = 2;
                end else begin
                    if (r != '1) r = r + 1'b1;
                    if (sp) fin = 0;
                end
            end
        end
        if (fin >= 0) begin
            for (int k = c; k <= ncyc; k++) begin
                o = '0; o.pc = p; o.ret = r; o.halted = (fin == 1); o.error = (fin == 2);
                put(k, o);
            end
        end
        model_ret = r;
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic do_reset();
        obs_t o;
        @(negedge clk);
        resetn = 1'b0; start = 1'b0; stop = 1'b0; hang_add = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        o = sample();
        n_chk++;
        if (o !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", o, obs_t'(0));
        end
        resetn = 1'b1;
        model_ret = '0;
    endtask

    task automatic run_scn(input string nm, input logic [AW-1:0] sa, input int stop_cyc, input bit hg, input int ncyc);
        hang_add = hg;
        build_model(sa, stop_cyc, hg, ncyc);
        @(negedge clk);
        start = 1'b1; start_addr = sa; stop = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = (c == stop_cyc);
            #1;
            act_a[c]  = sample();
            done_a[c] = done;
            n_chk++;
            if (act_a[c] !== exp_a[c]) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %h want %h", nm, c, act_a[c], exp_a[c]);
            end
        end
        stop = 1'b0;
    endtask

    function automatic logic [8:0] rand_word();
        int         r;
        logic [2:0] op;
        r = $urandom_range(0, 19);
        if      (r < 3)  op = 3'b000;
        else if (r < 6)  op = 3'b001;
        else if (r < 9)  op = 3'b010;
        else if (r < 12) op = 3'b011;
        else if (r < 16) op = 3'b100;
        else if (r < 18) op = 3'b111;
        else if (r < 19) op = 3'b101;
        else             op = 3'b110;
        return {op, 6'($urandom_range(0, 63))};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 9'h1C0;
    endtask

    initial begin
        int runs;
        resetn = 1'b0; start = 1'b0; stop = 1'b0; start_addr = '0; hang_add = 1'b0;
        model_ret = '0;

        // MVI R0,#5; HALT
        do_reset();
        clear_rom();
        rom[0] = 9'h100; rom[1] = 9'd5; rom[2] = 9'h1C0;
        run_scn("mvi_halt", 5'd0, -1, 1'b0, 10);
        chk("mvi_issue_run", 32'(act_a[2].run), 1);
        chk("mvi_issue_din", 32'(act_a[2].din), 32'h100);
        chk("mvi_imm_din", 32'(act_a[3].din), 5);
        chk("mvi_done_cyc", 32'(done_a[4]), 1);
        chk("mvi_halted", 32'(act_a[6].halted), 1);
        chk("mvi_pc", 32'(act_a[6].pc), 2);
        chk("mvi_retired", 32'(act_a[6].ret), 1);
        chk("mvi_r0", 32'(R[0]), 5);

        // MVI R0,#3; MVI R1,#4; ADD R0,R1; HALT
        do_reset();
        clear_rom();
        rom[0] = 9'h100; rom[1] = 9'd3; rom[2] = 9'h108; rom[3] = 9'd4; rom[4] = 9'h081;
        run_scn("add_prog", 5'd0, -1, 1'b0, 16);
        runs = 0;
        for (int c = 1; c <= 16; c++) runs += int'(act_a[c].run);
        chk("add_run_cycles", 32'(runs), 10);
        chk("add_run_gapless", 32'(act_a[5].run && act_a[8].run), 1);
        chk("add_r0", 32'(R[0]), 7);
        chk("add_retired", 32'(act_a[16].ret), 3);

        // Illegal opcode from HALTED, then restart clears error
        rom[0] = 9'h140; rom[1] = 9'h1C0;
        run_scn("illegal", 5'd0, -1, 1'b0, 8);
        chk("ill_no_err_c2", 32'(act_a[2].error), 0);
        chk("ill_err_c3", 32'(act_a[3].error), 1);
        runs = 0;
        for (int c = 1; c <= 8; c++) runs += int'(act_a[c].run);
        chk("ill_no_run", 32'(runs), 0);
        chk("ill_pc", 32'(act_a[8].pc), 0);
        run_scn("ill_restart", 5'd1, -1, 1'b0, 6);
        chk("ill_err_cleared", 32'(act_a[1].error), 0);
        chk("ill_restart_halt", 32'(act_a[3].halted), 1);

        // Core never answers an ADD: watchdog trips after TIMEOUT WAIT cycles
        do_reset();
        clear_rom();
        rom[0] = 9'h081;
        run_scn("timeout", 5'd0, -1, 1'b1, 14);
        chk("to_wait_last", 32'(act_a[9].run), 1);
        chk("to_no_err_c9", 32'(act_a[9].error), 0);
        chk("to_err_c10", 32'(act_a[10].error), 1);
        chk("to_run_low", 32'(act_a[11].run), 0);

        // stop during ADD WAIT: ADD retires, then IDLE; resume later
        do_reset();
        clear_rom();
        rom[0] = 9'h081; rom[1] = 9'h000;
        run_scn("stop_wait", 5'd0, 3, 1'b0, 10);
        chk("stop_done_c5", 32'(done_a[5]), 1);
        chk("stop_idle", 32'(act_a[6].busy), 0);
        chk("stop_no_fetch", 32'(act_a[6].mem_rd), 0);
        chk("stop_retired", 32'(act_a[6].ret), 1);
        run_scn("stop_resume", 5'd1, -1, 1'b0, 8);
        chk("resume_halt", 32'(act_a[5].halted), 1);
        chk("resume_retired", 32'(act_a[5].ret), 2);

        // MVI at the last address: immediate comes from address 0
        do_reset();
        clear_rom();
        rom[31] = 9'h110; rom[0] = 9'd9; rom[1] = 9'h1C0;
        run_scn("wrap", 5'd31, -1, 1'b0, 10);
        chk("wrap_imm_addr", 32'(act_a[2].addr), 0);
        chk("wrap_imm_din", 32'(act_a[3].din), 9);
        chk("wrap_pc", 32'(act_a[10].pc), 1);
        chk("wrap_r2", 32'(R[2]), 9);

        // Reset during IMM
        rom[4] = 9'h100; rom[5] = 9'd1;
        @(negedge clk); start = 1'b1; start_addr = 5'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("rst_imm_run", 32'(run), 1);
        resetn = 1'b0;
        @(negedge clk); #1;
        chk("rst_run", 32'(run), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_retired", 32'(retired), 0);
        resetn = 1'b1;
        model_ret = '0;

        // Random programs, start points, stop pulses and hung ADDs
        for (int it = 0; it < 25; it++) begin
            logic [AW-1:0] sa;
            int            sc;
            do_reset();
            for (int i = 0; i < 32; i++) rom[i] = rand_word();
            sa = AW'($urandom_range(0, 31));
            sc = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 30));
            run_scn("random", sa, sc, ($urandom_range(0, 3) == 0), 120);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
